// File: rtl/kf8237_request_arbiter.sv
// KF8237 request arbiter: merges DREQ, mask and software requests into one
// winning channel, runs the HRQ/HLDA handshake, drives DACK and tells the
// timing block which channel is active and when its service ends.
module kf8237_request_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       master_clear,
  input  logic [3:0] dma_request,
  input  logic       dreq_sense_active_low,
  input  logic       dack_sense_active_high,
  input  logic       rotating_priority,
  input  logic       controller_disable,
  input  logic [3:0] mask_register,
  input  logic [3:0] request_register,
  input  logic [7:0] transfer_mode,
  input  logic       hold_acknowledge,
  input  logic       transfer_done,
  input  logic       terminal_count,
  input  logic       end_of_process,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic [1:0] active_channel,
  output logic       channel_active,
  output logic [3:0] clear_software_request,
  output logic [3:0] tc_status
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_DEMAND  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SINGLE  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BLOCK   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_CASCADE = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HLDA = 3'd1,
    ACTIVE    = 3'd2,
    CASCADE   = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   prio_ptr;
  logic [NUM_CH-1:0] dack_int;

  logic [NUM_CH-1:0] eff_c;
  logic [CH_W-1:0]   search_start_c;
  logic [CH_W-1:0]   probe_c;
  logic [CH_W-1:0]   winner_c;
  logic              winner_found_c;
  logic              eff_active_c;
  logic [MODE_W-1:0] active_mode_c;
  logic [NUM_CH-1:0] active_onehot_c;
  logic              finish_c;
  logic              clr_pulse_c;
  logic              tc_pulse_c;

  // Effective request: polarity-corrected, masked DREQ plus unmaskable software requests
  always_comb begin
    eff_c = ((dma_request ^ {NUM_CH{dreq_sense_active_low}}) & ~mask_register)
            | request_register;
  end

  // Circular priority search starting at channel 0 (fixed) or prio_ptr (rotating)
  always_comb begin
    search_start_c = rotating_priority ? prio_ptr : '0;
    winner_c       = '0;
    winner_found_c = 1'b0;
    probe_c        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      probe_c = search_start_c + CH_W'(k);
      if (!winner_found_c && eff_c[probe_c]) begin
        winner_c       = probe_c;
        winner_found_c = 1'b1;
      end
    end
  end

  // Per-channel views of the latched winner
  always_comb begin
    eff_active_c    = eff_c[active_channel];
    active_mode_c   = transfer_mode[{active_channel, 1'b0} +: MODE_W];
    active_onehot_c = NUM_CH'(1) << active_channel;
  end

  // Decide whether the running service ends this cycle and which pulses go with it
  always_comb begin
    finish_c    = 1'b0;
    clr_pulse_c = 1'b0;
    tc_pulse_c  = 1'b0;
    case (state)
      ACTIVE: begin
        if (!hold_acknowledge) begin
          finish_c = 1'b1;
        end else if (transfer_done) begin
          if (terminal_count || end_of_process) begin
            finish_c    = 1'b1;
            clr_pulse_c = 1'b1;
            tc_pulse_c  = 1'b1;
          end else begin
            case (active_mode_c)
              MODE_BLOCK:  finish_c = 1'b0;
              MODE_DEMAND: finish_c = !eff_active_c;
              MODE_SINGLE: finish_c = 1'b1;
              default:     finish_c = 1'b1;
            endcase
          end
        end else if (end_of_process) begin
          finish_c    = 1'b1;
          clr_pulse_c = 1'b1;
        end
      end
      CASCADE: begin
        finish_c = !hold_acknowledge || !eff_active_c;
      end
      default: begin
        finish_c = 1'b0;
      end
    endcase
  end

  // Service sequencer with registered handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      prio_ptr               <= '0;
      active_channel         <= '0;
      dack_int               <= '0;
      hold_request           <= 1'b0;
      channel_active         <= 1'b0;
      clear_software_request <= '0;
      tc_status              <= '0;
    end else if (master_clear) begin
      state                  <= IDLE;
      prio_ptr               <= '0;
      active_channel         <= '0;
      dack_int               <= '0;
      hold_request           <= 1'b0;
      channel_active         <= 1'b0;
      clear_software_request <= '0;
      tc_status              <= '0;
    end else begin
      clear_software_request <= clr_pulse_c ? active_onehot_c : '0;
      tc_status              <= tc_pulse_c ? active_onehot_c : '0;
      case (state)
        IDLE: begin
          if (winner_found_c && !controller_disable) begin
            active_channel <= winner_c;
            hold_request   <= 1'b1;
            state          <= WAIT_HLDA;
          end
        end
        WAIT_HLDA: begin
          if (!eff_active_c) begin
            hold_request <= 1'b0;
            state        <= IDLE;
          end else if (hold_acknowledge) begin
            dack_int <= active_onehot_c;
            if (active_mode_c == MODE_CASCADE) begin
              state <= CASCADE;
            end else begin
              channel_active <= 1'b1;
              state          <= ACTIVE;
            end
          end
        end
        ACTIVE, CASCADE: begin
          if (finish_c) begin
            dack_int       <= '0;
            channel_active <= 1'b0;
            hold_request   <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (rotating_priority) begin
            prio_ptr <= active_channel + CH_W'(1);
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // DACK pin polarity
  assign dma_acknowledge = dack_int ^ {NUM_CH{~dack_sense_active_high}};

endmodule
